// File: rtl/rsp_dma_sequencer.sv
// Purpose: upstream DMA sequencer for the RSP bus. It takes one request and issues 64-bit beats to the bus/memory interface.
// Latency: read beats are combinational in the RUN cycle, and their DBUS write enable follows RD_LAT_* cycles later. Write beats assert the DBUS read enable first and the memory strobe one cycle after it.
// Backpressure: bus_stall freezes beat issue while in RUN. req_ready is high only in IDLE.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req_*               transfer request (valid/ready handshake, dir, imem, start word, words-1)
//   bus_stall           downstream DBUS not ready
//   dma_*               per-beat address, mask, read/write strobes and IMEM select
//   dbus_*_enable       downstream data register capture/drive enables
//   busy, done, err     status: not idle, end-of-transfer pulse, sticky address overrun
//
// Optional feature macro: RSP_DMA_WRAP_EN. When it is defined, the word address wraps at the top of the 4 KB window.
// When it is not defined, the transfer truncates at word 0xFFC and err is flagged.
module rsp_dma_sequencer #(
  parameter int RD_LAT_DMEM = 2,
  parameter int RD_LAT_IMEM = 4,
  parameter int CNT_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_dir,
  input  logic             req_imem,
  input  logic [11:2]      req_addr,
  input  logic [CNT_W-1:0] req_count,
  input  logic             bus_stall,
  output logic [11:3]      dma_address,
  output logic [1:0]       dma_mask,
  output logic             dma_dm_to_rd,
  output logic             dma_rd_to_dm,
  output logic             dma_imem_select,
  output logic             dbus_read_enable,
  output logic             dbus_write_enable,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // The shift register must be at least 2 deep so that the slice below stays legal.
  localparam int SR_D = (RD_LAT_IMEM > RD_LAT_DMEM) ? RD_LAT_IMEM : RD_LAT_DMEM;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             dir_q;
  logic             imem_q;
  logic [11:2]      cur;
  logic [CNT_W:0]   rem;
  logic [SR_D-1:0]  sr;
  logic             wr_pend;
  logic [11:3]      wr_addr;
  logic [1:0]       wr_mask;

  logic             accept;
  logic             beat;
  logic             rd_beat;
  logic             wr_beat;
  logic [1:0]       mask_c;
  logic [1:0]       step;
  logic [11:2]      cur_nxt;
  logic [CNT_W:0]   rem_nxt;
  logic             last;
  logic             in_flight;
  logic             drained;

  assign accept  = req_valid && (state == IDLE);
  assign beat    = (state == RUN) && !bus_stall;
  assign rd_beat = beat && !dir_q;
  assign wr_beat = beat && dir_q;

  // An odd start word takes only the low half. A single remaining even word takes only the high half.
  always_comb begin
    mask_c = 2'b11;
    if (cur[2]) begin
      mask_c = 2'b01;
    end else if (rem == (CNT_W+1)'(1)) begin
      mask_c = 2'b10;
    end
  end

  assign step    = (mask_c == 2'b11) ? 2'd2 : 2'd1;
  assign rem_nxt = rem - (CNT_W+1)'(step);

`ifdef RSP_DMA_WRAP_EN
  // Plain 10-bit arithmetic wraps 0xFFC back to 0x000.
  assign cur_nxt = cur + 10'(step);
  assign last    = (rem_nxt == '0);
  assign err     = 1'b0;
`else
  logic carry;
  logic overrun;
  logic err_q;

  assign {carry, cur_nxt} = {1'b0, cur} + 11'(step);
  // Words are still left, but the next word would fall outside the window.
  assign overrun = carry && (rem_nxt != '0);
  assign last    = (rem_nxt == '0) || overrun;
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (beat && overrun) begin
      err_q <= 1'b1;
    end
  end
`endif

  // Only the taps at or below the active latency still count as read beats in flight.
  always_comb begin
    in_flight = 1'b0;
    for (int i = 0; i < SR_D; i++) begin
      if (sr[i] && (i < (imem_q ? RD_LAT_IMEM : RD_LAT_DMEM))) begin
        in_flight = 1'b1;
      end
    end
  end

  assign drained = !in_flight && !wr_pend;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = RUN;
      RUN:     if (beat && last) state_nxt = DRAIN;
      DRAIN:   if (drained) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dir_q   <= 1'b0;
      imem_q  <= 1'b0;
      cur     <= '0;
      rem     <= '0;
      sr      <= '0;
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_mask <= '0;
    end else begin
      state   <= state_nxt;
      sr      <= {sr[SR_D-2:0], rd_beat};
      wr_pend <= wr_beat;
      if (wr_beat) begin
        wr_addr <= cur[11:3];
        wr_mask <= mask_c;
      end
      if (accept) begin
        dir_q  <= req_dir;
        imem_q <= req_imem;
        cur    <= req_addr;
        rem    <= {1'b0, req_count} + (CNT_W+1)'(1);
      end else if (beat) begin
        cur <= cur_nxt;
        rem <= rem_nxt;
      end
    end
  end

  assign req_ready         = (state == IDLE);
  assign busy              = (state != IDLE);
  assign done              = (state == DRAIN) && drained;
  assign dma_imem_select   = imem_q;
  assign dma_dm_to_rd      = rd_beat;
  assign dbus_read_enable  = wr_beat;
  assign dma_rd_to_dm      = wr_pend;
  assign dbus_write_enable = imem_q ? sr[RD_LAT_IMEM-1] : sr[RD_LAT_DMEM-1];

  // A read beat and a pending write strobe never coexist, because dir is fixed for a whole transfer.
  always_comb begin
    dma_address = '0;
    dma_mask    = '0;
    if (wr_pend) begin
      dma_address = wr_addr;
      dma_mask    = wr_mask;
    end else if (rd_beat) begin
      dma_address = cur[11:3];
      dma_mask    = mask_c;
    end
  end

endmodule

// File: tb/tb_rsp_dma_sequencer.sv
// Purpose: self-checking bench for rsp_dma_sequencer. It uses a word-list and timeline reference model.
// Latency: the model predicts the cycle of every beat, enable and done from the stall pattern.
// Backpressure: bus_stall is scheduled per cycle, either directed or random.
module tb_rsp_dma_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_dir = 1'b0;
  logic        req_imem = 1'b0;
  logic [11:2] req_addr = '0;
  logic [9:0]  req_count = '0;
  logic        bus_stall = 1'b0;
  logic [11:3] dma_address;
  logic [1:0]  dma_mask;
  logic        dma_dm_to_rd;
  logic        dma_rd_to_dm;
  logic        dma_imem_select;
  logic        dbus_read_enable;
  logic        dbus_write_enable;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

`ifdef RSP_DMA_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  rsp_dma_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir), .req_imem(req_imem),
    .req_addr(req_addr), .req_count(req_count), .bus_stall(bus_stall),
    .dma_address(dma_address), .dma_mask(dma_mask), .dma_dm_to_rd(dma_dm_to_rd),
    .dma_rd_to_dm(dma_rd_to_dm), .dma_imem_select(dma_imem_select),
    .dbus_read_enable(dbus_read_enable), .dbus_write_enable(dbus_write_enable),
    .busy(busy), .done(done), .err(err)
  );

  // Bit order: ready busy done err imem dm_to_rd rd_to_dm rd_en wr_en mask[1:0] addr[8:0].
  function automatic logic [19:0] obs();
    return {req_ready, busy, done, err, dma_imem_select, dma_dm_to_rd, dma_rd_to_dm,
            dbus_read_enable, dbus_write_enable, dma_mask, dma_address};
  endfunction

  // The task is entered and left at a sample point, 2 time units after a posedge, in an IDLE cycle.
  task automatic run_xfer(input string name, input bit dir, input bit imem,
                          input int addr, input int count, input int smode);
    int baddr[$];
    int bmask[$];
    bit exp_err;
    int wa, rem, n, m, bc, last, lat, donecyc, nb;
    bit stall[256];
    int beat_at[256];
    logic [19:0] ev, av;

    // Reference model: build the word-level beat list from the start word and the length.
    wa = addr; rem = count + 1; exp_err = 1'b0;
    while (rem > 0) begin
      if (wa % 2 == 1) begin m = 1; n = 1; end
      else if (rem == 1) begin m = 2; n = 1; end
      else begin m = 3; n = 2; end
      baddr.push_back(wa / 2);
      bmask.push_back(m);
      wa += n; rem -= n;
      if (wa >= 1024) begin
        if (WRAP) wa -= 1024;
        else begin
          if (rem > 0) exp_err = 1'b1;
          break;
        end
      end
    end
    nb = baddr.size();

    // Timeline model: cycle 0 is the accept cycle, and each unstalled cycle from 1 onward issues the next beat.
    bc = 0; last = 0;
    for (int c = 0; c < 256; c++) begin
      beat_at[c] = -1;
      stall[c] = 1'b0;
    end
    for (int c = 1; c < 256; c++) begin
      case (smode)
        1: stall[c] = (c < 200) && ($urandom_range(0, 99) < 30);
        2: stall[c] = (c >= 2) && (c <= 4);
        default: stall[c] = 1'b0;
      endcase
      if (!stall[c] && bc < nb) begin
        beat_at[c] = bc;
        last = c;
        bc++;
      end
    end
    lat = imem ? 4 : 2;
    donecyc = dir ? last + 2 : last + lat + 1;

    req_valid = 1'b1; req_dir = dir; req_imem = imem;
    req_addr = 10'(addr); req_count = 10'(count);
    bus_stall = 1'($urandom_range(0, 1));
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: ready=%b busy=%b expected ready=1 busy=0", name, req_ready, busy);
    end

    for (int c = 1; c <= donecyc + 1; c++) begin
      @(posedge clk); #1;
      // Requests presented while busy must be ignored. The final cycle is IDLE, so it must not present one.
      req_valid = (c <= donecyc) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_dir   = 1'($urandom_range(0, 1));
      req_imem  = 1'($urandom_range(0, 1));
      req_addr  = 10'($urandom);
      req_count = 10'($urandom);
      bus_stall = stall[c];
      #1;
      ev = '0;
      ev[19] = (c > donecyc);
      ev[18] = (c <= donecyc);
      ev[17] = (c == donecyc);
      ev[16] = exp_err && (c > last);
      ev[15] = imem;
      if (!dir && beat_at[c] >= 0) begin
        ev[14]   = 1'b1;
        ev[10:9] = 2'(bmask[beat_at[c]]);
        ev[8:0]  = 9'(baddr[beat_at[c]]);
      end
      if (dir && beat_at[c] >= 0) ev[12] = 1'b1;
      if (dir && beat_at[c-1] >= 0) begin
        ev[13]   = 1'b1;
        ev[10:9] = 2'(bmask[beat_at[c-1]]);
        ev[8:0]  = 9'(baddr[beat_at[c-1]]);
      end
      if (!dir && c - lat >= 1 && beat_at[c-lat] >= 0) ev[11] = 1'b1;
      av = obs();
      // The IMEM select is defined only while the transfer is active.
      if (c > donecyc) av[15] = ev[15];
      checks++;
      if (av !== ev) begin
        errors++;
        $display("FAIL %s cycle %0d: outputs=%h expected=%h", name, c, av, ev);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (obs() !== 20'h80000) begin
      errors++;
      $display("FAIL reset: outputs=%h expected=%h", obs(), 20'h80000);
    end
    rst = 1'b0;
  endtask

  task automatic test_dmem_read();
    run_xfer("dmem_read", 1'b0, 1'b0, 'h010 >> 2, 3, 0);
  endtask

  task automatic test_dmem_write();
    run_xfer("dmem_write", 1'b1, 1'b0, 'h014 >> 2, 1, 0);
    run_xfer("dmem_write3", 1'b1, 1'b0, 'h014 >> 2, 2, 0);
  endtask

  task automatic test_imem_read();
    run_xfer("imem_read", 1'b0, 1'b1, 0, 0, 0);
  endtask

  task automatic test_stall();
    run_xfer("stall_rd", 1'b0, 1'b0, 'h040 >> 2, 11, 2);
    run_xfer("stall_wr", 1'b1, 1'b1, 'h044 >> 2, 11, 2);
  endtask

  task automatic test_overrun();
    run_xfer("overrun_rd", 1'b0, 1'b0, 'hFF8 >> 2, 3, 0);
    run_xfer("overrun_wr", 1'b1, 1'b1, 'hFF8 >> 2, 3, 1);
  endtask

  task automatic test_back_to_back();
    run_xfer("b2b_a", 1'b0, 1'b1, 'h100 >> 2, 5, 0);
    run_xfer("b2b_b", 1'b1, 1'b0, 'h104 >> 2, 4, 0);
  endtask

  task automatic test_random();
    int a;
    for (int i = 0; i < 12; i++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(1010, 1023) : $urandom_range(0, 1023);
      run_xfer("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               a, $urandom_range(0, 15), 1);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_dir = 1'b0; req_imem = 1'b0;
    req_addr = '0; req_count = 10'd20; bus_stall = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (obs() !== 20'h80000) begin
      errors++;
      $display("FAIL reset_mid: outputs=%h expected=%h", obs(), 20'h80000);
    end
    // A new request goes into the first cycle after the reset. Stale in-flight state would show up as extra enables or a done pulse.
    run_xfer("after_reset", 1'b0, 1'b0, 'h020 >> 2, 2, 0);
  endtask

  initial begin
    test_reset();
    test_dmem_read();
    test_dmem_write();
    test_imem_read();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
